// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : imem_fetch_ctrl_pkg                                      |
// | Brief   : Shared pipeline types for the instruction fetch control. |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package imem_fetch_ctrl_pkg;

  // S_HOLD: no read outstanding. S_REQ: one read outstanding at addr_q.
  typedef enum logic [0:0] {
    S_HOLD = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_t;

  // Instruction word presented to the fetch stage while it is stalled.
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sat_counter                                              |
// | Brief   : Up-counter that sticks at all-ones instead of wrapping.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count requested cycles, holding once the maximum is reached.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != MAX_VAL)) begin
      count_o <= count_o + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : imem_fetch_ctrl                                          |
// | Brief   : One-entry instruction buffer in front of a ready-based   |
// |           instruction memory; stalls fetch until the word for the  |
// |           current PC is held, and counts stalled cycles.           |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_f_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ready_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      instr_f_o,
  output logic             fetch_stall_o,
  output logic [CNT_W-1:0] wait_cycles_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  tag_q,   tag_d;
  logic         valid_q, valid_d;
  logic [31:0]  addr_q,  addr_d;
  logic         hit;

  assign hit        = valid_q && (tag_q == pc_f_i);
  assign mem_addr_o = addr_q;

  // State and buffer registers; reset empties the buffer and abandons any read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_HOLD;
      instr_q <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, buffer update and fetch-side outputs.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    addr_d        = addr_q;
    mem_req_o     = 1'b0;
    fetch_stall_o = 1'b1;
    instr_f_o     = NOP;
    case (state_q)
      S_HOLD: begin
        // A stray mem_ready_i here is ignored: nothing is outstanding.
        if (hit) begin
          fetch_stall_o = 1'b0;
          instr_f_o     = instr_q;
        end else begin
          state_d = S_REQ;
          addr_d  = pc_f_i;
        end
      end
      S_REQ: begin
        // The read always completes against addr_q, even if the PC moved;
        // a moved PC simply misses again in S_HOLD.
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          instr_d = mem_rdata_i;
          tag_d   = addr_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (fetch_stall_o),
    .count_o (wait_cycles_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_imem_fetch_ctrl                                       |
// | Brief   : Scoreboard bench for imem_fetch_ctrl with a transaction  |
// |           level reference of the fetch buffer.                     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_f_i;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  logic        mem_req_o,  req4;
  logic [31:0] mem_addr_o, addr4;
  logic [31:0] instr_f_o,  instr4;
  logic        fetch_stall_o, stall4;
  logic [15:0] wait_cycles_o;
  logic [3:0]  wait4;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk_i (clk), .rst_i (rst_i), .pc_f_i (pc_f_i),
    .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o),
    .mem_ready_i (mem_ready_i), .mem_rdata_i (mem_rdata_i),
    .instr_f_o (instr_f_o), .fetch_stall_o (fetch_stall_o),
    .wait_cycles_o (wait_cycles_o)
  );

  // Narrow-counter instance so saturation is reached within the run.
  imem_fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk_i (clk), .rst_i (rst_i), .pc_f_i (pc_f_i),
    .mem_req_o (req4), .mem_addr_o (addr4),
    .mem_ready_i (mem_ready_i), .mem_rdata_i (mem_rdata_i),
    .instr_f_o (instr4), .fetch_stall_o (stall4),
    .wait_cycles_o (wait4)
  );

  typedef struct {
    int          cyc;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        stall;
    logic [15:0] w16;
    logic [3:0]  w4;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference: buffered word, one optional outstanding read, stall count.
  bit          m_valid;
  logic [31:0] m_tag, m_data, m_addr;
  bit          m_out;
  int          m_stalls;

  logic [31:0] pcs [6] = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008,
                           32'h0040_0100, 32'h0040_0200, 32'h0040_0300};

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0040_0004) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the expected outputs go to the scoreboard.
  task automatic step(input logic [31:0] pc, input bit rdy, input bit rst);
    exp_t e;
    bit   hit;
    @(posedge clk);
    #1;
    pc_f_i      = pc;
    mem_ready_i = rdy;
    rst_i       = rst;
    mem_rdata_i = (rdy && mem_req_o) ? mem_fn(mem_addr_o) : $urandom;
    cyc++;
    e.cyc = cyc;
    if (!rst) begin
      m_valid = 0; m_tag = '0; m_data = '0; m_addr = '0; m_out = 0; m_stalls = 0;
      e.req = 1'b0; e.addr = '0; e.instr = '0; e.stall = 1'b1; e.w16 = '0; e.w4 = '0;
    end else begin
      hit     = m_valid && (m_tag == pc);
      e.req   = m_out;
      e.addr  = m_addr;
      e.stall = m_out || !hit;
      e.instr = (!m_out && hit) ? m_data : 32'h0;
      e.w16   = 16'(sat(m_stalls, 65535));
      e.w4    = 4'(sat(m_stalls, 15));
      if (m_out) begin
        if (rdy) begin
          m_data  = mem_fn(m_addr);
          m_tag   = m_addr;
          m_valid = 1;
          m_out   = 0;
        end
      end else if (!hit) begin
        m_out  = 1;
        m_addr = pc;
      end
      if (e.stall) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem_req",  e.cyc, {31'b0, mem_req_o},     {31'b0, e.req});
      chk("mem_addr", e.cyc, mem_addr_o,             e.addr);
      chk("instr",    e.cyc, instr_f_o,              e.instr);
      chk("stall",    e.cyc, {31'b0, fetch_stall_o}, {31'b0, e.stall});
      chk("wait16",   e.cyc, {16'b0, wait_cycles_o}, {16'b0, e.w16});
      chk("wait4",    e.cyc, {28'b0, wait4},         {28'b0, e.w4});
    end
  end

  initial begin
    logic [31:0] pc;
    rst_i = 1'b0; pc_f_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    m_valid = 0; m_tag = '0; m_data = '0; m_addr = '0; m_out = 0; m_stalls = 0;

    // Held in reset with a memory claiming ready.
    repeat (3) step(32'h0040_0000, 1'b1, 1'b0);
    // Release: zero-wait memory at 0x0040_0000.
    repeat (5) step(32'h0040_0000, 1'b1, 1'b1);
    // Three wait cycles at 0x0040_0004.
    step(32'h0040_0004, 1'b0, 1'b1);
    repeat (3) step(32'h0040_0004, 1'b0, 1'b1);
    step(32'h0040_0004, 1'b1, 1'b1);
    repeat (3) step(32'h0040_0004, 1'b0, 1'b1);
    // PC redirect while the 0x0040_0008 read is in flight.
    step(32'h0040_0008, 1'b0, 1'b1);
    step(32'h0040_0008, 1'b0, 1'b1);
    step(32'h0040_0100, 1'b0, 1'b1);
    repeat (6) step(32'h0040_0100, 1'b1, 1'b1);
    // Hit held for ten cycles; ready noise must be ignored.
    repeat (10) step(32'h0040_0100, 1'($urandom_range(1)), 1'b1);
    // PC wanders during a request and returns to the fetched address.
    step(32'h0040_0300, 1'b0, 1'b1);
    step(32'h0040_0400, 1'b0, 1'b1);
    step(32'h0040_0300, 1'b1, 1'b1);
    repeat (3) step(32'h0040_0300, 1'b0, 1'b1);
    // Reset in the middle of a request, then late ready after release.
    step(32'h0040_0500, 1'b0, 1'b1);
    step(32'h0040_0500, 1'b0, 1'b1);
    step(32'h0040_0500, 1'b0, 1'b0);
    repeat (2) step(32'h0040_0500, 1'b1, 1'b1);
    repeat (2) step(32'h0040_0500, 1'b0, 1'b1);
    // Long stall run to saturate the narrow counter.
    step(32'h0040_0600, 1'b0, 1'b0);
    repeat (22) step(32'h0040_0600, 1'b0, 1'b1);
    step(32'h0040_0600, 1'b1, 1'b1);
    repeat (2) step(32'h0040_0600, 1'b0, 1'b1);
    // Randomized traffic.
    pc = pcs[0];
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) pc = pcs[$urandom_range(5)];
      step(pc, ($urandom_range(9) < 4), ($urandom_range(49) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
